// File: rtl/bsram_coh_accum_ctrl.sv
// Coherent-integration controller: accumulates I/Q correlator samples per bin into a
// single-port 1024x36 BSRAM over NACC passes, then streams the integrated bins out.
module bsram_coh_accum_ctrl #(
  parameter int NBINS = 1024,
  parameter int NACC  = 8,
  parameter int IN_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_i,
  input  logic signed [IN_W-1:0] in_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [17:0]     out_i,
  output logic signed [17:0]     out_q,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  input  logic [35:0]            ram_do,
  output logic [35:0]            ram_di,
  output logic [9:0]             ram_ad,
  output logic                   ram_wre,
  output logic                   ram_ce
);

  localparam logic [9:0] BIN_LAST  = 10'(NBINS - 1);
  localparam logic [7:0] PASS_LAST = 8'(NACC - 1);

  typedef enum logic [2:0] {
    IDLE, ACC_IN, ACC_RD, ACC_WAIT, ACC_WR, DMP_RD, DMP_WAIT, DMP_OUT
  } state_t;

  state_t      state_reg;
  logic [9:0]  bin_reg;
  logic [7:0]  pass_reg;
  logic [17:0] s_i_reg, s_q_reg;
  logic        in_ready_reg, out_valid_reg, out_last_reg, busy_reg, done_reg;
  logic [17:0] out_i_reg, out_q_reg;
  logic [35:0] ram_di_reg;
  logic [9:0]  ram_ad_reg;
  logic        ram_wre_reg;

  logic [35:0] samp_word;
  logic [35:0] sat_word;

  assign samp_word = {s_i_reg, s_q_reg};

  // Lane 0 is Q (bits 17:0), lane 1 is I (bits 35:18); each adds at 19b and clamps to 18b.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [18:0] sum;
      assign sum = 19'($signed(ram_do[gi*18 +: 18])) + 19'($signed(samp_word[gi*18 +: 18]));
      assign sat_word[gi*18 +: 18] = (sum[18] != sum[17]) ?
                                     (sum[18] ? 18'h20000 : 18'h1ffff) : sum[17:0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      pass_reg      <= '0;
      s_i_reg       <= '0;
      s_q_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_i_reg     <= '0;
      out_q_reg     <= '0;
      ram_di_reg    <= '0;
      ram_ad_reg    <= '0;
      ram_wre_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done_reg) begin
            bin_reg      <= '0;
            pass_reg     <= '0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            state_reg    <= ACC_IN;
          end
        end
        ACC_IN: begin
          if (in_valid && in_ready_reg) begin
            s_i_reg      <= 18'(in_i);
            s_q_reg      <= 18'(in_q);
            ram_ad_reg   <= bin_reg;
            in_ready_reg <= 1'b0;
            if (pass_reg == 8'd0) begin
              ram_di_reg  <= {18'(in_i), 18'(in_q)};
              ram_wre_reg <= 1'b1;
              state_reg   <= ACC_WR;
            end else begin
              ram_wre_reg <= 1'b0;
              state_reg   <= ACC_RD;
            end
          end
        end
        ACC_RD: state_reg <= ACC_WAIT;
        ACC_WAIT: begin
          ram_di_reg  <= sat_word;
          ram_wre_reg <= 1'b1;
          state_reg   <= ACC_WR;
        end
        ACC_WR: begin
          ram_wre_reg <= 1'b0;
          if (bin_reg != BIN_LAST) begin
            bin_reg      <= bin_reg + 10'd1;
            in_ready_reg <= 1'b1;
            state_reg    <= ACC_IN;
          end else begin
            bin_reg <= '0;
            if (pass_reg != PASS_LAST) begin
              pass_reg     <= pass_reg + 8'd1;
              in_ready_reg <= 1'b1;
              state_reg    <= ACC_IN;
            end else begin
              ram_ad_reg <= '0;
              state_reg  <= DMP_RD;
            end
          end
        end
        DMP_RD: state_reg <= DMP_WAIT;
        DMP_WAIT: begin
          out_i_reg     <= ram_do[35:18];
          out_q_reg     <= ram_do[17:0];
          out_valid_reg <= 1'b1;
          out_last_reg  <= (bin_reg == BIN_LAST);
          state_reg     <= DMP_OUT;
        end
        DMP_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            if (out_last_reg) begin
              bin_reg   <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              bin_reg    <= bin_reg + 10'd1;
              ram_ad_reg <= bin_reg + 10'd1;
              state_reg  <= DMP_RD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_i     = out_i_reg;
  assign out_q     = out_q_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign ram_di    = ram_di_reg;
  assign ram_ad    = ram_ad_reg;
  assign ram_wre   = ram_wre_reg;
  assign ram_ce    = 1'b1;

endmodule
